// File: rtl/wb_trace_fifo_if.sv
// Regfile write-port tap plus trace drain handshake for wb_trace_fifo.
// slave  : the trace FIFO (consumes the write port, sources the drain port)
// master : processor/host side (drives the write port, consumes the drain port)
`timescale 1ns/1ps
interface wb_trace_fifo_if #(
   parameter int CYC_W = 10
) ();
   logic             ctrl_writeEnable;
   logic [4:0]       ctrl_writeReg;
   logic [31:0]      data_writeReg;
   logic             out_valid;
   logic             out_ready;
   logic [CYC_W-1:0] out_cycle;
   logic [4:0]       out_reg;
   logic [31:0]      out_data;

   modport slave (
      input  ctrl_writeEnable,
      input  ctrl_writeReg,
      input  data_writeReg,
      input  out_ready,
      output out_valid,
      output out_cycle,
      output out_reg,
      output out_data
   );

   modport master (
      output ctrl_writeEnable,
      output ctrl_writeReg,
      output data_writeReg,
      output out_ready,
      input  out_valid,
      input  out_cycle,
      input  out_reg,
      input  out_data
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// Register-write trace capture FIFO.
// Timestamps every write to a non-zero architectural register and queues it
// for a first-word-fall-through valid/ready drain. Writes arriving while the
// queue is full (and not being popped that cycle) are dropped and counted.
`timescale 1ns/1ps
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int CYC_W = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    capture_en,
   input  logic                    clear,
   wb_trace_fifo_if.slave          bus,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [15:0]             drop_count,
   output logic [CYC_W-1:0]        cycle_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = CYC_W + 5 + 32;
   localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT_C = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0] ZERO_PTR_C = {PTR_W{1'b0}};
   localparam logic [15:0]      DROP_MAX_C = 16'hFFFF;

   // Entry layout: {timestamp, register number, data}
   logic [ENT_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_q, drop_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;

   logic             push_s;
   logic             pop_s;
   logic             accept_s;
   logic             drop_s;
   logic             write_mem_s;
   logic [ENT_W-1:0] head_s;
   logic [ENT_W-1:0] entry_s;

   // A write qualifies only when capturing and the target is not r0.
   assign push_s      = capture_en & bus.ctrl_writeEnable & (bus.ctrl_writeReg != 5'd0);
   // Pop depends only on registered occupancy, never feeding back into outputs.
   assign pop_s       = (count_q != ZERO_CNT_C) & bus.out_ready;
   // A same-cycle pop frees a slot, so a full queue can still accept.
   assign accept_s    = push_s & ((count_q != FULL_C) | pop_s);
   assign drop_s      = push_s & ~accept_s;
   assign write_mem_s = accept_s & ~clear;
   assign entry_s     = {cyc_q, bus.ctrl_writeReg, bus.data_writeReg};

   // Next-state computation for pointers, occupancy, overflow and counters.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      cyc_d      = cyc_q;
      if (clear) begin
         wr_ptr_d   = ZERO_PTR_C;
         rd_ptr_d   = ZERO_PTR_C;
         count_d    = ZERO_CNT_C;
         overflow_d = 1'b0;
         drop_d     = 16'd0;
         cyc_d      = {CYC_W{1'b0}};
      end else begin
         if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_q != DROP_MAX_C) begin
               drop_d = drop_q + 16'd1;
            end else begin
               drop_d = drop_q;
            end
         end else begin
            overflow_d = overflow_q;
            drop_d     = drop_q;
         end
         cyc_d = cyc_q + CYC_W'(1);
      end
   end

   // Control and status registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= ZERO_PTR_C;
         rd_ptr_q   <= ZERO_PTR_C;
         count_q    <= ZERO_CNT_C;
         overflow_q <= 1'b0;
         drop_q     <= 16'd0;
         cyc_q      <= {CYC_W{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         cyc_q      <= cyc_d;
      end
   end

   // Trace storage; contents are don't-care until pointed at by a valid head.
   always_ff @(posedge clock) begin
      if (write_mem_s) begin
         mem_q[wr_ptr_q] <= entry_s;
      end
   end

   // Head slot drives the drain port directly (fall-through).
   assign head_s        = mem_q[rd_ptr_q];
   assign bus.out_valid = (count_q != ZERO_CNT_C);
   assign bus.out_cycle = head_s[ENT_W-1 -: CYC_W];
   assign bus.out_reg   = head_s[36:32];
   assign bus.out_data  = head_s[31:0];

   assign count       = count_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_q;
   assign cycle_count = cyc_q;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: a queue model predicts pushes, drops and
// pops; each scenario task compares DUT outputs against it and against constants.
`timescale 1ns/1ps
module tb_wb_trace_fifo;
   localparam int DEPTH = 16;
   localparam int CYC_W = 10;

   typedef struct packed {
      logic [CYC_W-1:0] cyc;
      logic [4:0]       rg;
      logic [31:0]      data;
   } ent_t;

   logic              clock;
   logic              reset;
   logic              capture_en;
   logic              clear;
   logic [4:0]        count;
   logic              overflow;
   logic [15:0]       drop_count;
   logic [CYC_W-1:0]  cycle_count;

   wb_trace_fifo_if #(.CYC_W(CYC_W)) bus ();

   wb_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .capture_en  (capture_en),
      .clear       (clear),
      .bus         (bus.slave),
      .count       (count),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .cycle_count (cycle_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // scoreboard / model state
   ent_t             sb[$];
   logic [CYC_W-1:0] m_cyc;
   logic             m_ovf;
   logic [15:0]      m_drop;
   ent_t             last_pop;
   ent_t             pre_out;
   logic             pre_valid;
   logic             pre_ready;
   logic             popped;
   int               n_checks;
   int               n_pass;

   task automatic set_in(input logic cap, input logic we, input logic [4:0] rg,
                         input logic [31:0] d, input logic rdy, input logic clr);
      capture_en           = cap;
      bus.ctrl_writeEnable = we;
      bus.ctrl_writeReg    = rg;
      bus.data_writeReg    = d;
      bus.out_ready        = rdy;
      clear                = clr;
   endtask

   task automatic model_reset();
      sb.delete();
      m_cyc  = '0;
      m_ovf  = 1'b0;
      m_drop = 16'd0;
   endtask

   // Predict the effect of the next rising edge, then advance to edge+1.
   task automatic edge_model();
      logic push;
      logic pop;
      pre_out   = {bus.out_cycle, bus.out_reg, bus.out_data};
      pre_valid = bus.out_valid;
      pre_ready = bus.out_ready;
      push = capture_en && bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
      pop  = (sb.size() != 0) && bus.out_ready;
      popped = 1'b0;
      if (clear) begin
         model_reset();
      end else begin
         if (pop) begin
            last_pop = sb.pop_front();
            popped   = 1'b1;
         end
         if (push) begin
            if (sb.size() < DEPTH) begin
               sb.push_back({m_cyc, bus.ctrl_writeReg, bus.data_writeReg});
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
         end
         m_cyc = m_cyc + 10'd1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop got=%0d exp=0", drop_count); else n_pass++;
      n_checks++; if (cycle_count !== 10'd0) $display("FAIL reset_cycle got=%0d exp=0", cycle_count); else n_pass++;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      int   npop;
      ent_t exp_e;
      npop = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 2)      set_in(1'b1, 1'b1, 5'd3, 32'd5, 1'b1, 1'b0);
         else if (c == 4) set_in(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
         else             set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
         edge_model();
         if (c == 2) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", bus.out_valid); else n_pass++;
         end
         if (popped) begin
            exp_e = (npop == 0) ? {10'd2, 5'd3, 32'd5} : {10'd4, 5'd7, 32'hFFFF_FFFF};
            n_checks++; if (pre_out !== exp_e) $display("FAIL basic_entry%0d got=%h exp=%h", npop, pre_out, exp_e); else n_pass++;
            npop++;
         end
         n_checks++; if (count !== 5'(sb.size())) $display("FAIL basic_count got=%0d exp=%0d", count, sb.size()); else n_pass++;
      end
      n_checks++; if (npop != 2) $display("FAIL basic_npop got=%0d exp=2", npop); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL basic_overflow got=%b exp=0", overflow); else n_pass++;
   endtask

   task automatic test_filter();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) set_in(1'b1, 1'b1, 5'd0, 32'd99, 1'b1, 1'b0);
         else        set_in(1'b0, 1'b1, 5'd4, 32'd123, 1'b1, 1'b0);
         edge_model();
         n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL filter_valid%0d got=%b exp=0", k, bus.out_valid); else n_pass++;
         n_checks++; if (count !== 5'd0) $display("FAIL filter_count%0d got=%0d exp=0", k, count); else n_pass++;
         n_checks++; if (cycle_count !== m_cyc) $display("FAIL filter_cycle%0d got=%0d exp=%0d", k, cycle_count, m_cyc); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      ent_t exp_e;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      edge_model();
      for (int i = 1; i <= 18; i++) begin
         set_in(1'b1, 1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
         edge_model();
      end
      n_checks++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd2) $display("FAIL ovf_drop got=%0d exp=2", drop_count); else n_pass++;
      for (int k = 0; k < 16; k++) begin
         set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
         edge_model();
         exp_e = {10'(k), 5'(k + 1), 32'(k + 1)};
         n_checks++;
         if (!popped) $display("FAIL ovf_drain%0d got=nopop exp=pop", k);
         else if (pre_out !== exp_e) $display("FAIL ovf_drain%0d got=%h exp=%h", k, pre_out, exp_e);
         else n_pass++;
      end
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      ent_t exp_e;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      edge_model();
      for (int i = 1; i <= 16; i++) begin
         set_in(1'b1, 1'b1, 5'(i), 32'(i * 3), 1'b0, 1'b0);
         edge_model();
      end
      set_in(1'b1, 1'b1, 5'd20, 32'd7, 1'b1, 1'b0);
      edge_model();
      n_checks++; if (drop_count !== 16'd0) $display("FAIL fpp_drop got=%0d exp=0", drop_count); else n_pass++;
      n_checks++; if (count !== 5'd16) $display("FAIL fpp_count got=%0d exp=16", count); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL fpp_overflow got=%b exp=0", overflow); else n_pass++;
      for (int k = 0; k < 20 && bus.out_valid; k++) begin
         set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
         edge_model();
         if (popped) begin
            n_checks++; if (pre_out !== last_pop) $display("FAIL fpp_order got=%h exp=%h", pre_out, last_pop); else n_pass++;
         end
      end
      exp_e = {10'd0, 5'd20, 32'd7};
      n_checks++;
      if ({pre_out.rg, pre_out.data} !== {exp_e.rg, exp_e.data}) $display("FAIL fpp_last got=%h exp=%h", {pre_out.rg, pre_out.data}, {exp_e.rg, exp_e.data});
      else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fpp_empty got=%b exp=0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int errs;
      errs = 0;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      edge_model();
      for (int i = 0; i < 80; i++) begin
         set_in(1'b1, (i % 3) != 2, 5'($urandom_range(1, 31)), $urandom(), ((i % 2) == 1), 1'b0);
         edge_model();
         if (popped) begin
            n_checks++; if (pre_out !== last_pop) $display("FAIL b2b_order%0d got=%h exp=%h", i, pre_out, last_pop); else n_pass++;
         end
         if (pre_valid && !pre_ready) begin
            n_checks++;
            if ({bus.out_cycle, bus.out_reg, bus.out_data} !== pre_out)
               $display("FAIL b2b_stall%0d got=%h exp=%h", i, {bus.out_cycle, bus.out_reg, bus.out_data}, pre_out);
            else n_pass++;
         end
         if (count !== 5'(sb.size())) errs++;
      end
      for (int k = 0; k < 40 && sb.size() != 0; k++) begin
         set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
         edge_model();
         if (popped) begin
            n_checks++; if (pre_out !== last_pop) $display("FAIL b2b_drain got=%h exp=%h", pre_out, last_pop); else n_pass++;
         end
      end
      n_checks++; if (errs != 0) $display("FAIL b2b_count got=%0d_errors exp=0", errs); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_cycle_wrap();
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      edge_model();
      for (int i = 0; i < 1025; i++) begin
         set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
         edge_model();
      end
      set_in(1'b1, 1'b1, 5'd9, 32'h0000_ABCD, 1'b0, 1'b0);
      edge_model();
      n_checks++; if (bus.out_cycle !== 10'd1) $display("FAIL wrap_stamp got=%0d exp=1", bus.out_cycle); else n_pass++;
      n_checks++; if (bus.out_reg !== 5'd9) $display("FAIL wrap_reg got=%0d exp=9", bus.out_reg); else n_pass++;
      set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      edge_model();
      n_checks++;
      if (!popped || pre_out !== last_pop) $display("FAIL wrap_pop got=%h exp=%h", pre_out, last_pop); else n_pass++;
   endtask

   task automatic test_clear_reset();
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      edge_model();
      for (int i = 1; i <= 5; i++) begin
         set_in(1'b1, 1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
         edge_model();
      end
      set_in(1'b1, 1'b1, 5'd11, 32'd55, 1'b0, 1'b1);
      edge_model();
      n_checks++; if (count !== 5'd0) $display("FAIL clr_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL clr_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (cycle_count !== 10'd0) $display("FAIL clr_cycle got=%0d exp=0", cycle_count); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clr_valid got=%b exp=0", bus.out_valid); else n_pass++;
      // refill past full so overflow and drop_count are non-zero before reset
      for (int i = 1; i <= 17; i++) begin
         set_in(1'b1, 1'b1, 5'(i), 32'(i), (i == 17), 1'b0);
         if (i == 17) bus.out_ready = 1'b0;
         edge_model();
      end
      set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL rst_pre_overflow got=%b exp=1", overflow); else n_pass++;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (count !== 5'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.out_valid); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop got=%0d exp=0", drop_count); else n_pass++;
      n_checks++; if (cycle_count !== 10'd0) $display("FAIL rst_cycle got=%0d exp=0", cycle_count); else n_pass++;
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      #1;
      reset = 1'b1;
      edge_model();
      n_checks++; if (cycle_count !== 10'd1) $display("FAIL rst_cycle_run got=%0d exp=1", cycle_count); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL rst_count_run got=%0d exp=0", count); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_filter();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_cycle_wrap();
      test_clear_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
Capture buffer that sits directly downstream of the processor's regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg). Every architectural register write to a non-zero register is timestamped with a free-running cycle count and queued. The test harness or a host-side logger drains the queue through a valid/ready port, so write traces survive without per-cycle polling.

Parameters:
DEPTH, 16, number of trace entries; power of two, >= 2
CYC_W, 10, width of the cycle timestamp; wraps modulo 2^CYC_W

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion
capture_en  in  1  1 = record qualifying writes; 0 = ignore the write port (cycle counter still runs)
clear  in  1  synchronous flush of queue, flags and counters
ctrl_writeEnable  in  1  regfile write enable from processor
ctrl_writeReg  in  5  destination register of the write
data_writeReg  in  32  data being written
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_cycle  out  CYC_W  timestamp of head entry
out_reg  out  5  register number of head entry
out_data  out  32  data of head entry
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; a qualifying write was dropped because the queue was full
drop_count  out  16  number of dropped writes; saturates at 16'hFFFF
cycle_count  out  CYC_W  current cycle counter value

Behaviour:
- Reset (reset=0, asynchronous): count=0, out_valid=0, overflow=0, drop_count=0, cycle_count=0. Read/write pointers are 0. Storage contents need not be cleared; out_cycle/out_reg/out_data are don't-care while out_valid=0.
- cycle_count increments by 1 on every rising edge while out of reset and clear=0, and wraps from 2^CYC_W-1 to 0.
- The first rising edge after reset release is cycle 0.
- Qualifying write at an edge: capture_en=1, ctrl_writeEnable=1 and ctrl_writeReg!=0.
  - The entry is {cycle_count before increment, ctrl_writeReg, data_writeReg}.
  - A write to r0 is never recorded.
- Pop at an edge: out_valid=1 and out_ready=1. The head advances and count decrements.
- Queue is first-word-fall-through.
  - out_valid = (count!=0).
  - out_* are driven from the head storage slot, with no extra latency.
  - A pushed entry is visible on out_* in the cycle after the push edge when the queue was empty. Push-to-out_valid latency is 1 cycle.
- Push with count<DEPTH: the entry is written at the write pointer, the pointer increments and wraps at DEPTH.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, a same-cycle pop frees the slot, so the push is accepted and nothing is dropped.
  - When count=1, a same-cycle push and pop leaves the new entry as the head.
- Push when full with no pop: the entry is discarded, overflow is set to 1 (sticky), and drop_count increments, saturating at 16'hFFFF. Queue contents are unchanged.
- Pop with out_valid=0: ignored, no underflow, count stays 0.
- out_ready may be asserted at any time. out_* must stay stable while out_valid=1 and out_ready=0.
- clear=1 at an edge sets count=0, both pointers=0, overflow=0, drop_count=0, cycle_count=0. Clear dominates any same-cycle push or pop; the write in that cycle is not recorded.
- Reset asserted mid-operation (queue partly full, pop in flight): all state returns to reset values immediately, without waiting for a clock edge. In-flight entries are lost.
- No combinational path from out_ready to out_valid, count or any out_* signal.

Test Plan:
- Basic capture: after reset, writes of r3=5 at cycle 2 and r7=-1 at cycle 4, out_ready=1 -> out sequence {cycle 2, reg 3, 32'd5} then {cycle 4, reg 7, 32'hFFFFFFFF}. count returns to 0 and overflow=0.
- Filtering: writes to r0=99 and to r4 with capture_en=0 -> out_valid stays 0 and count=0. cycle_count still advances by 1 per cycle.
- Fill/overflow: out_ready=0, 18 consecutive writes r1..r18 with data=i -> count=16, overflow=1, drop_count=2. Draining yields r1..r16 in order with timestamps 0..15, after which out_valid=0.
- Full push+pop: with the queue full, a write r20=7 and a pop in the same cycle -> drop_count unchanged, count=16. The last entry drained is {reg 20, data 7}.
- Backpressure and wrap: entries pushed and popped alternately 40 times with out_ready toggling -> pointer wrap is exercised, order is preserved, and out_* are stable while stalled. With CYC_W=10, a write at cycle 1025 reports timestamp 1.
- Clear/reset mid-operation: with 5 entries queued, clear=1 together with a write -> count=0, overflow=0, cycle_count=0, and the write is absent. Repeat with reset pulsed low between clock edges -> outputs are cleared before the next edge.
